// File: rtl/otter_pc_pkg.sv
// Shared types and constants for the OTTER program-counter unit.
package otter_pc_pkg;

    typedef enum logic [2:0] {
        PC_NEXT   = 3'd0,
        PC_JALR   = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JUMP   = 3'd3,
        PC_MTVEC  = 3'd4,
        PC_MEPC   = 3'd5
    } pc_sel_t;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_history_buf.sv
// Circular buffer of pre-load PCs for non-sequential fetches; index 0 reads the newest entry.
module pc_history_buf #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned IW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [IW-1:0]     idx_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [IW-1:0]     wr_ptr_q;
    logic [IW:0]       count_q;
    logic [IW-1:0]     rd_ptr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (push_i) begin
            mem_q[wr_ptr_q] <= pc_i;
            wr_ptr_q        <= wr_ptr_q + IW'(1);
            if (count_q != (IW+1)'(DEPTH)) begin
                count_q <= count_q + (IW+1)'(1);
            end
        end
    end

    // wr_ptr_q points at the next free slot, so the newest entry is one behind it.
    always_comb begin
        rd_ptr = wr_ptr_q - IW'(1) - idx_i;
        pc_o   = ({1'b0, idx_i} < count_q) ? mem_q[rd_ptr] : '0;
    end

endmodule

// File: rtl/pc_sequencer.sv
// OTTER fetch-stage PC unit: next-PC select, latched interrupt vectoring, EPC capture.
// Optional PC history buffer is built when PC_HISTORY_EN is defined.
module pc_sequencer
    import otter_pc_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC  = '0,
    parameter int unsigned        HIST_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          PC_WE,
    input  logic [2:0]                    PC_SEL,
    input  logic [ADDR_W-1:0]             JALR,
    input  logic [ADDR_W-1:0]             BRANCH,
    input  logic [ADDR_W-1:0]             JUMP,
    input  logic [ADDR_W-1:0]             MTVEC,
    input  logic [ADDR_W-1:0]             MEPC,
    input  logic                          INTR,
    input  logic                          INTR_EN,
    output logic [ADDR_W-1:0]             PC,
    output logic [ADDR_W-1:0]             PC_PLUS4,
    output logic                          INTR_TAKEN,
    output logic [ADDR_W-1:0]             EPC,
    output logic                          MISALIGN,
    input  logic [$clog2(HIST_DEPTH)-1:0] HIST_IDX,
    output logic [ADDR_W-1:0]             HIST_PC
);

    logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d;
    logic              pend_q, pend_d, taken_q, taken_d, mis_q, mis_d;
    logic [ADDR_W-1:0] pc_plus4, sel_target, load_target;
    logic              set_cond, take, nonseq;

    always_comb begin
        pc_plus4 = pc_q + ADDR_W'(PC_INC);
        nonseq   = 1'b1;
        case (pc_sel_t'(PC_SEL))
            PC_JALR:   sel_target = {JALR[ADDR_W-1:1], 1'b0};
            PC_BRANCH: sel_target = BRANCH;
            PC_JUMP:   sel_target = JUMP;
            PC_MTVEC:  sel_target = MTVEC;
            PC_MEPC:   sel_target = MEPC;
            default: begin
                sel_target = pc_plus4;
                nonseq     = 1'b0;
            end
        endcase

        // A pending or freshly raised interrupt wins over whatever PC_SEL asks for.
        set_cond    = INTR & INTR_EN;
        take        = PC_WE & (pend_q | set_cond);
        load_target = take ? MTVEC : sel_target;

        pc_d    = pc_q;
        epc_d   = epc_q;
        pend_d  = pend_q | set_cond;
        taken_d = 1'b0;
        mis_d   = 1'b0;
        if (PC_WE) begin
            pc_d  = {load_target[ADDR_W-1:2], 2'b00};
            mis_d = load_target[1];
            if (take) begin
                epc_d   = {sel_target[ADDR_W-1:2], 2'b00};
                taken_d = 1'b1;
                pend_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            pend_q  <= 1'b0;
            taken_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            pend_q  <= pend_d;
            taken_q <= taken_d;
            mis_q   <= mis_d;
        end
    end

    assign PC         = pc_q;
    assign PC_PLUS4   = pc_plus4;
    assign EPC        = epc_q;
    assign INTR_TAKEN = taken_q;
    assign MISALIGN   = mis_q;

`ifdef PC_HISTORY_EN
    logic unused_lsb;
    assign unused_lsb = load_target[0] ^ JALR[0];

    pc_history_buf #(
        .ADDR_W (ADDR_W),
        .DEPTH  (HIST_DEPTH)
    ) u_hist (
        .clk_i  (CLK),
        .rst_i  (RST),
        .push_i (PC_WE & (take | nonseq)),
        .pc_i   (pc_q),
        .idx_i  (HIST_IDX),
        .pc_o   (HIST_PC)
    );
`else
    logic unused_lsb;
    assign unused_lsb = load_target[0] ^ JALR[0] ^ nonseq ^ (^HIST_IDX);
    assign HIST_PC    = '0;
`endif

endmodule
